// File: rtl/leading_one_normalizer_pipe_pkg.sv
// Shared definitions for the leading/trailing-one normaliser.
//   mode_e : operating mode (leading-one left-align / trailing-one right-align)
//   clog2  : ceiling log2, used to size the location/shift-amount fields
package leading_one_normalizer_pipe_pkg;

  typedef enum logic {
    MODE_LEAD  = 1'b0,
    MODE_TRAIL = 1'b1
  } mode_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/leading_one_normalizer_pipe_encoder.sv
// Combinational one-position encoder.
//   data : operand
//   mode : MODE_LEAD -> index of highest set bit, MODE_TRAIL -> index of lowest set bit
//   loc  : detected index (0 when data is all zeros)
//   zero : data is all zeros
module one_position_encoder
  import leading_one_normalizer_pipe_pkg::*;
#(
  parameter  int unsigned WIDTH = 50,
  localparam int unsigned LOC_W = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  mode_e            mode,
  output logic [LOC_W-1:0] loc,
  output logic             zero
);

  // Scan order is chosen so the last hit wins: ascending for the highest
  // set bit, descending for the lowest.
  always_comb begin
    loc  = '0;
    zero = ~|data;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (mode == MODE_LEAD) begin
        if (data[i]) loc = LOC_W'(i);
      end else begin
        if (data[WIDTH-1-i]) loc = LOC_W'(WIDTH-1-i);
      end
    end
  end

endmodule

// File: rtl/leading_one_normalizer_pipe.sv
// Two-stage pipelined normaliser with valid/ready on both sides.
// Stage 1 registers the operand with its leading/trailing-one location;
// stage 2 registers the shift amount and the normalised operand.
//   i_clk, i_rst_n             : clock (rising edge), async active-low reset
//   i_in_valid / o_in_ready    : input handshake
//   i_data, i_mode             : operand and mode (0 lead/left-align, 1 trail/right-align)
//   o_out_valid / i_out_ready  : output handshake
//   o_location, o_shamt        : detected bit index and applied shift
//   o_shifted, o_zero          : normalised operand, operand-was-zero flag
module leading_one_normalizer_pipe
  import leading_one_normalizer_pipe_pkg::*;
#(
  parameter  int unsigned WIDTH = 50,
  localparam int unsigned LOC_W = clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_mode,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [LOC_W-1:0] o_location,
  output logic [LOC_W-1:0] o_shamt,
  output logic [WIDTH-1:0] o_shifted,
  output logic             o_zero
);

  // Reset asserts asynchronously, releases on a clock edge two cycles later.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  // Handshake
  logic s1_valid;
  logic s2_valid;
  logic adv1;
  logic adv2;

  assign adv2       = !s2_valid || i_out_ready;
  assign adv1       = !s1_valid || adv2;
  assign o_in_ready = adv1;

  // Stage 1
  mode_e            in_mode;
  logic [LOC_W-1:0] in_loc;
  logic             in_zero;

  assign in_mode = mode_e'(i_mode);

  one_position_encoder #(.WIDTH(WIDTH)) u_encoder (
    .data (i_data),
    .mode (in_mode),
    .loc  (in_loc),
    .zero (in_zero)
  );

  logic [WIDTH-1:0] s1_data;
  mode_e            s1_mode;
  logic [LOC_W-1:0] s1_loc;
  logic             s1_zero;

  always_ff @(posedge i_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= MODE_LEAD;
      s1_loc   <= '0;
      s1_zero  <= 1'b0;
    end else if (adv1) begin
      s1_valid <= i_in_valid;
      if (i_in_valid) begin
        s1_data <= i_data;
        s1_mode <= in_mode;
        s1_loc  <= in_loc;
        s1_zero <= in_zero;
      end
    end
  end

  // Stage 2: shift amount and barrel shift from stage-1 contents.
  // A zero operand in lead mode shifts by WIDTH-1, which still yields zero.
  logic [LOC_W-1:0] s1_shamt;
  logic [WIDTH-1:0] s1_shifted;

  always_comb begin
    s1_shamt   = '0;
    s1_shifted = '0;
    if (s1_mode == MODE_LEAD) begin
      s1_shamt   = LOC_W'(WIDTH - 1) - s1_loc;
      s1_shifted = s1_data << s1_shamt;
    end else begin
      s1_shamt   = s1_loc;
      s1_shifted = s1_data >> s1_shamt;
    end
  end

  logic [LOC_W-1:0] s2_loc;
  logic [LOC_W-1:0] s2_shamt;
  logic [WIDTH-1:0] s2_shifted;
  logic             s2_zero;

  always_ff @(posedge i_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      s2_valid   <= 1'b0;
      s2_loc     <= '0;
      s2_shamt   <= '0;
      s2_shifted <= '0;
      s2_zero    <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_loc     <= s1_loc;
        s2_shamt   <= s1_shamt;
        s2_shifted <= s1_shifted;
        s2_zero    <= s1_zero;
      end
    end
  end

  assign o_out_valid = s2_valid;
  assign o_location  = s2_loc;
  assign o_shamt     = s2_shamt;
  assign o_shifted   = s2_shifted;
  assign o_zero      = s2_zero;

endmodule

// File: tb/tb_leading_one_normalizer_pipe.sv
// Directed bench for leading_one_normalizer_pipe at WIDTH = 50.
module tb_leading_one_normalizer_pipe;

  localparam int unsigned W  = 50;
  localparam int unsigned LW = 6;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [W-1:0]  data      = '0;
  logic          mode      = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [LW-1:0] loc;
  logic [LW-1:0] shamt;
  logic [W-1:0]  shifted;
  logic          zero;

  always #5 clk = ~clk;

  leading_one_normalizer_pipe #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_data      (data),
    .i_mode      (mode),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_location  (loc),
    .o_shamt     (shamt),
    .o_shifted   (shifted),
    .o_zero      (zero)
  );

  typedef struct {
    logic [W-1:0]  data;
    logic          mode;
    logic [LW-1:0] loc;
    logic [LW-1:0] shamt;
    logic [W-1:0]  shifted;
    logic          zero;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, ".valid"},   64'(out_valid), 64'd1);
    check({tag, ".loc"},     64'(loc),       64'(v.loc));
    check({tag, ".shamt"},   64'(shamt),     64'(v.shamt));
    check({tag, ".shifted"}, 64'(shifted),   64'(v.shifted));
    check({tag, ".zero"},    64'(zero),      64'(v.zero));
  endtask

  function automatic vec_t mk(input logic [W-1:0] d, input logic m, input logic [LW-1:0] l,
                              input logic [LW-1:0] s, input logic [W-1:0] sh, input logic z);
    vec_t v;
    v.data = d; v.mode = m; v.loc = l; v.shamt = s; v.shifted = sh; v.zero = z;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   sent;
    int   rcv;
    logic held_v;
    logic [62:0] held;

    vecs[0]  = mk(50'h2_0000_0000_0000, 1'b0, 6'd49, 6'd0,  50'h2_0000_0000_0000, 1'b0);
    vecs[1]  = mk(50'h0_0000_0000_0001, 1'b0, 6'd0,  6'd49, 50'h2_0000_0000_0000, 1'b0);
    vecs[2]  = mk(50'h2_0000_0000_0008, 1'b1, 6'd3,  6'd3,  50'h0_4000_0000_0001, 1'b0);
    vecs[3]  = mk(50'h0,                1'b0, 6'd0,  6'd49, 50'h0,                1'b1);
    vecs[4]  = mk(50'h0,                1'b1, 6'd0,  6'd0,  50'h0,                1'b1);
    vecs[5]  = mk(50'h0_0000_0000_0001, 1'b1, 6'd0,  6'd0,  50'h0_0000_0000_0001, 1'b0);
    vecs[6]  = mk(50'h0_0000_1234_0000, 1'b0, 6'd28, 6'd21, 50'h2_4680_0000_0000, 1'b0);
    vecs[7]  = mk(50'h0_0000_1234_0000, 1'b1, 6'd18, 6'd18, 50'h0_0000_0000_048D, 1'b0);
    vecs[8]  = mk(50'h3_FFFF_FFFF_FFFF, 1'b0, 6'd49, 6'd0,  50'h3_FFFF_FFFF_FFFF, 1'b0);
    vecs[9]  = mk(50'h3_FFFF_FFFF_FFFF, 1'b1, 6'd0,  6'd0,  50'h3_FFFF_FFFF_FFFF, 1'b0);
    vecs[10] = mk(50'h3_0000_0000_0000, 1'b1, 6'd48, 6'd48, 50'h0_0000_0000_0003, 1'b0);
    vecs[11] = mk(50'h3_0000_0000_0000, 1'b0, 6'd49, 6'd0,  50'h3_0000_0000_0000, 1'b0);
    vecs[12] = mk(50'h0_0000_0000_0002, 1'b0, 6'd1,  6'd48, 50'h2_0000_0000_0000, 1'b0);
    vecs[13] = mk(50'h0_8000_0000_0000, 1'b1, 6'd47, 6'd47, 50'h0_0000_0000_0001, 1'b0);

    // Reset and idle state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle.out_valid", 64'(out_valid), 64'd0);
    check("idle.in_ready",  64'(in_ready),  64'd1);
    check("idle.loc",       64'(loc),       64'd0);
    check("idle.shamt",     64'(shamt),     64'd0);
    check("idle.shifted",   64'(shifted),   64'd0);
    check("idle.zero",      64'(zero),      64'd0);

    // Back-to-back table stream, ready high: each result exactly 2 cycles later
    out_ready = 1'b1;
    for (int i = 0; i < NV + 2; i++) begin
      if (i >= 2) check_vec($sformatf("vec%0d", i - 2), vecs[i-2]);
      else        check("latency.no_early_valid", 64'(out_valid), 64'd0);
      if (i < NV) begin
        in_valid = 1'b1;
        data     = vecs[i].data;
        mode     = vecs[i].mode;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("drain.out_valid", 64'(out_valid), 64'd0);

    // Backpressure: 6 beats, random output ready, in-order delivery and stall stability
    sent   = 0;
    rcv    = 0;
    held_v = 1'b0;
    held   = '0;
    for (int cyc = 0; cyc < 300 && rcv < 6; cyc++) begin
      if (held_v) begin
        check("stall.valid_held", 64'(out_valid), 64'd1);
        check("stall.data_held",  64'({loc, shamt, shifted, zero}), 64'(held));
      end
      out_ready = (cyc < 4) ? 1'b0 : 1'($urandom_range(0, 1));
      in_valid  = (sent < 6);
      if (sent < 6) begin
        data = vecs[6+sent].data;
        mode = vecs[6+sent].mode;
      end
      #1;
      check("bp.in_ready", 64'(in_ready), 64'(!((sent - rcv) == 2 && !out_ready)));
      held_v = out_valid && !out_ready;
      held   = {loc, shamt, shifted, zero};
      if (out_valid && out_ready) begin
        check_vec($sformatf("bp%0d", rcv), vecs[6+rcv]);
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    check("bp.received", 64'(rcv),  64'd6);
    check("bp.sent",     64'(sent), 64'd6);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset with two beats in flight
    in_valid = 1'b1;
    data     = vecs[0].data;
    mode     = vecs[0].mode;
    @(negedge clk);
    data     = vecs[1].data;
    mode     = vecs[1].mode;
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("arst.out_valid", 64'(out_valid), 64'd0);
    check("arst.loc",       64'(loc),       64'd0);
    check("arst.shamt",     64'(shamt),     64'd0);
    check("arst.shifted",   64'(shifted),   64'd0);
    check("arst.zero",      64'(zero),      64'd0);
    check("arst.in_ready",  64'(in_ready),  64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst.no_ghost", 64'(out_valid), 64'd0);
    end
    in_valid = 1'b1;
    data     = vecs[2].data;
    mode     = vecs[2].mode;
    @(negedge clk);
    in_valid = 1'b0;
    check("post_rst.not_yet", 64'(out_valid), 64'd0);
    @(negedge clk);
    check_vec("post_rst.new", vecs[2]);
    @(negedge clk);
    check("post_rst.single", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
